mem_access_unit: RTL

- MEM stage of the MIPS pipeline; sits directly downstream of the EX-stage ALU.
- Takes the ALU result as the effective address for loads/stores, or as a pass-through value for all other instructions.
- Performs byte/halfword/word accesses on an internal word-organised data memory.
- Registers everything into the MEM/WB boundary: load data sign/zero-extended, misaligned accesses trapped.

---
 rtl/mem_access_unit.sv | 135 +++++++++++++
 1 files changed

// File: rtl/mem_access_unit.sv
// MIPS MEM stage: byte/half/word loads and stores on an internal word-organised
// data memory. Every accepted instruction reaches the MEM/WB register one cycle
// later. Misaligned loads and stores are trapped and their address is latched.
module mem_access_unit #(
  parameter int NB_DATA = 32,
  parameter int NB_ADDR = 8,
  parameter int NB_REG  = 5
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_valid,
  input  logic               i_flush,
  input  logic               i_mem_read,
  input  logic               i_mem_write,
  input  logic [1:0]         i_size,
  input  logic               i_unsigned,
  input  logic [NB_DATA-1:0] i_alu_result,
  input  logic [NB_DATA-1:0] i_store_data,
  input  logic [NB_REG-1:0]  i_rd_addr,
  input  logic               i_reg_write,
  input  logic [NB_ADDR-1:0] i_dbg_addr,
  output logic               o_valid,
  output logic [NB_DATA-1:0] o_wb_data,
  output logic [NB_REG-1:0]  o_rd_addr,
  output logic               o_reg_write,
  output logic               o_misaligned,
  output logic [NB_DATA-1:0] o_bad_addr,
  output logic [NB_DATA-1:0] o_dbg_data
);

  localparam int NB_LANE = NB_DATA / 8;

  logic [NB_DATA-1:0] r_mem [2**NB_ADDR];

  logic               r_valid;
  logic [NB_DATA-1:0] r_wb_data;
  logic [NB_REG-1:0]  r_rd_addr;
  logic               r_reg_write;
  logic               r_misaligned;
  logic [NB_DATA-1:0] r_bad_addr;

  logic               w_accept;
  logic               w_misaligned;
  logic               w_do_store;
  logic               w_do_load;
  logic [NB_ADDR-1:0] w_index;
  logic [1:0]         w_offset;
  logic [NB_LANE-1:0] w_be;
  logic [NB_DATA-1:0] w_wdata;
  logic [NB_DATA-1:0] w_rd_word;
  logic [NB_DATA-1:0] w_rd_shift;
  logic [NB_DATA-1:0] w_load_data;

  // Address split, alignment check, byte enables and store-lane replication.
  always_comb begin
    // NOTE: every signal gets a default first so no path through the case leaves it unassigned (no latch).
    w_index      = i_alu_result[NB_ADDR+1:2];
    w_offset     = i_alu_result[1:0];
    w_accept     = i_valid & ~i_flush;
    w_misaligned = 1'b0;
    w_be         = '1;
    w_wdata      = i_store_data;
    case (i_size)
      2'b00: begin
        w_be    = NB_LANE'(1) << w_offset;
        w_wdata = {NB_LANE{i_store_data[7:0]}};
      end
      2'b01: begin
        w_misaligned = w_offset[0];
        w_be         = NB_LANE'(3) << {w_offset[1], 1'b0};
        w_wdata      = {(NB_LANE/2){i_store_data[15:0]}};
      end
      default: w_misaligned = |w_offset;
    endcase
    w_misaligned = w_misaligned & (i_mem_read | i_mem_write);
    // A simultaneous read+write request is a store.
    w_do_store   = w_accept & i_mem_write & ~w_misaligned;
    w_do_load    = w_accept & i_mem_read & ~i_mem_write & ~w_misaligned;
  end

  // Load path: pick the addressed byte/half out of the word and extend it.
  always_comb begin
    w_rd_word   = r_mem[w_index];
    w_rd_shift  = w_rd_word >> {w_offset, 3'b000};
    w_load_data = w_rd_word;
    case (i_size)
      2'b00: w_load_data = i_unsigned ? {{(NB_DATA-8){1'b0}}, w_rd_shift[7:0]}
                                      : {{(NB_DATA-8){w_rd_shift[7]}}, w_rd_shift[7:0]};
      2'b01: w_load_data = i_unsigned ? {{(NB_DATA-16){1'b0}}, w_rd_shift[15:0]}
                                      : {{(NB_DATA-16){w_rd_shift[15]}}, w_rd_shift[15:0]};
      default: w_load_data = w_rd_word;
    endcase
  end

  // Byte-enabled store into the data memory; a reset on the same edge blocks it.
  // NOTE: the memory array deliberately has no reset branch, so it can map onto RAM.
  always_ff @(posedge i_clk) begin
    if (w_do_store && !i_rst) begin
      for (int l = 0; l < NB_LANE; l++) begin
        if (w_be[l]) r_mem[w_index][8*l +: 8] <= w_wdata[8*l +: 8];
      end
    end
  end

  // MEM/WB pipeline register, including the sticky misaligned-address capture.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_valid      <= 1'b0;
      r_wb_data    <= '0;
      r_rd_addr    <= '0;
      r_reg_write  <= 1'b0;
      r_misaligned <= 1'b0;
      r_bad_addr   <= '0;
    end else begin
      // NOTE: non-blocking assignments make every register sample pre-edge values.
      r_valid      <= w_accept;
      r_misaligned <= w_accept & w_misaligned;
      r_reg_write  <= w_accept & ~w_misaligned & ~i_mem_write & i_reg_write;
      if (w_accept) begin
        r_rd_addr <= i_rd_addr;
        r_wb_data <= w_do_load ? w_load_data : i_alu_result;
      end
      if (w_accept && w_misaligned) r_bad_addr <= i_alu_result;
    end
  end

  assign o_valid      = r_valid;
  assign o_wb_data    = r_wb_data;
  assign o_rd_addr    = r_rd_addr;
  assign o_reg_write  = r_reg_write;
  assign o_misaligned = r_misaligned;
  assign o_bad_addr   = r_bad_addr;
  assign o_dbg_data   = r_mem[i_dbg_addr];

endmodule
